uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL provide parameter DATA_BITS, default 8, the width of each received character.
REQ-002 The block SHALL provide parameter DEPTH, default 16, the number of entries, restricted to a power of two and at least 2.
REQ-003 The block SHALL provide port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL provide port rx_ready  input  1  one-cycle push strobe from the UART receiver.
REQ-006 The block SHALL provide port rx_data  input  DATA_BITS  the received character, valid when rx_ready=1.
REQ-007 The block SHALL provide port rx_error  input  1  the frame-error flag for the character, valid when rx_ready=1.
REQ-008 The block SHALL provide port rd_en  input  1  pop request from the consumer.
REQ-009 The block SHALL provide port ovf_clr  input  1  clear for the sticky overflow flag.
REQ-010 The block SHALL provide port rd_valid  output  1  one-cycle pulse marking rd_data/rd_frame_err as valid.
REQ-011 The block SHALL provide port rd_data  output  DATA_BITS  the popped character.
REQ-012 The block SHALL provide port rd_frame_err  output  1  the frame-error flag stored with the popped character.
REQ-013 The block SHALL provide port empty  output  1  high when count=0.
REQ-014 The block SHALL provide port full  output  1  high when count=DEPTH.
REQ-015 The block SHALL provide port count  output  log2(DEPTH)+1  the number of stored entries.
REQ-016 The block SHALL provide port overflow  output  1  sticky flag: a character was dropped.

Function
REQ-017 Each entry SHALL store {rx_error, rx_data}, DATA_BITS+1 bits.
REQ-018 A push SHALL occur on a cycle with rx_ready=1 and either full=0, or a pop accepted in the same cycle.
REQ-019 A pop SHALL be accepted on a cycle with rd_en=1 and empty=0; rd_en while empty SHALL be ignored, with no state change and no rd_valid.
REQ-020 The read latency SHALL be 1 cycle: the cycle after an accepted pop, rd_valid=1 and rd_data/rd_frame_err hold the oldest entry.
REQ-021 rd_data/rd_frame_err SHALL hold their last value when rd_valid=0.
REQ-022 Ordering SHALL be strict FIFO.
REQ-023 The write and read pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without special handling.
REQ-024 count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on push+pop or neither; empty/full SHALL be derived from the registered count.
REQ-025 Simultaneous push and pop when empty SHALL result in a push only; the pop is ignored, and count becomes 1 with no rd_valid next cycle.
REQ-026 Simultaneous push and pop when full SHALL both succeed, with count staying at DEPTH and no overflow.
REQ-027 rx_ready=1 when full without an accepted pop SHALL drop the character, leave the contents unchanged, and set overflow=1 on the next edge.
REQ-028 overflow SHALL clear on ovf_clr=1; if a drop and ovf_clr occur in the same cycle, overflow SHALL remain 1 (set wins).
REQ-029 rx_ready pulses SHALL be accepted on consecutive cycles, up to one per cycle.
REQ-030 The block SHALL contain no combinational path from rx_* to rd_* outputs.

Reset
REQ-031 When rst_n=0, the block SHALL immediately and asynchronously force: pointers=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0, rd_frame_err=0.
REQ-032 Storage array contents SHALL NOT require reset.
REQ-033 Assertion of rst_n mid-operation SHALL discard all stored entries, and a pop in flight SHALL NOT produce rd_valid.
REQ-034 Deassertion of rst_n SHALL be synchronous to clk at the integration level; the first push SHALL be accepted on the first edge after deassertion.

Verification
REQ-035 The bench SHALL cover: push 0x41 (err=0), 0x42 (err=1), then 0x43 (err=0) -> count=3; three pops -> rd_valid pulses carry 0x41/0, 0x42/1, 0x43/0 in order; empty=1 afterwards.
REQ-036 The bench SHALL cover: push 17 characters 0x00..0x10 with DEPTH=16 and no pops -> full=1 after 16, overflow=1 after the 17th; popping all yields 0x00..0x0F and never 0x10.
REQ-037 The bench SHALL cover: full FIFO, then rx_ready+rd_en in the same cycle with 0xAA -> count stays 16, overflow stays 0, and 0xAA is the last entry popped.
REQ-038 The bench SHALL cover: empty FIFO, then rx_ready(0x55)+rd_en in the same cycle -> no rd_valid next cycle, count=1; the next pop returns 0x55.
REQ-039 The bench SHALL cover: rd_en held high on an empty FIFO for 5 cycles -> rd_valid stays 0 and count stays 0; separately, drop and ovf_clr in the same cycle -> overflow=1, and ovf_clr alone next cycle -> overflow=0.
REQ-040 The bench SHALL cover: 40 pushes interleaved with pops to wrap the pointers twice, then rst_n pulsed low mid-stream -> all outputs at reset values immediately; data pushed afterwards is returned correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO between a UART receiver and its consumer, storing frame-error flags with each character
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_ready,
    input  logic [DATA_BITS-1:0]     rx_data,
    input  logic                     rx_error,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic                     rd_valid,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic                     rd_frame_err,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DATA_BITS:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic               drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
    assign pop  = rd_en && !empty;
    assign push = rx_ready && (!full || pop);
    assign drop = rx_ready && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {rx_error, rx_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_frame_err <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr                  <= rd_ptr + 1'b1;
                {rd_frame_err, rd_data} <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set so the loss is never hidden.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_error;
    logic                 rd_en;
    logic                 ovf_clr;
    logic                 rd_valid;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_frame_err;
    logic                 empty;
    logic                 full;
    logic [4:0]           count;
    logic                 overflow;

    uart_rx_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_error(rx_error), .rd_en(rd_en), .ovf_clr(ovf_clr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_frame_err(rd_frame_err),
        .empty(empty), .full(full), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [8:0] model_q[$];
    logic [8:0] exp_q[$];
    logic       model_ovf;
    logic       exp_rv;
    int         n_push;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model applies the FIFO rules to a queue of {err,data}.
    task automatic step(input logic rr, input logic [7:0] d, input logic e,
                        input logic re, input logic oc);
        logic m_pop, m_full, m_push, m_drop;
        @(negedge clk);
        rx_ready = rr; rx_data = d; rx_error = e; rd_en = re; ovf_clr = oc;
        m_full = (model_q.size() == DEPTH);
        m_pop  = re && (model_q.size() > 0);
        m_push = rr && (!m_full || m_pop);
        m_drop = rr && m_full && !m_pop;
        if (m_pop) exp_q.push_back(model_q.pop_front());
        if (m_push) begin
            model_q.push_back({e, d});
            n_push++;
        end
        if (m_drop) model_ovf = 1'b1;
        else if (oc) model_ovf = 1'b0;
        exp_rv = m_pop;
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(model_q.size()));
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("full", 32'(full), 32'(model_q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(model_ovf));
        check("rd_valid", 32'(rd_valid), 32'(exp_rv));
        rx_ready = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_rd_frame_err"}, 32'(rd_frame_err), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Monitor: every rd_valid pulse must match the oldest outstanding expected entry.
    always @(posedge clk) begin
        #2;
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e[7:0]));
                check("rd_frame_err", 32'(rd_frame_err), 32'(e[8]));
            end
        end
    end

    initial begin
        logic [7:0] seq [3];
        logic       err [3];
        seq[0] = 8'h41; seq[1] = 8'h42; seq[2] = 8'h43;
        err[0] = 1'b0;  err[1] = 1'b1;  err[2] = 1'b0;
        model_ovf = 1'b0;
        n_push = 0;
        rst_n = 1'b0; rx_ready = 1'b0; rx_data = '0; rx_error = 1'b0;
        rd_en = 1'b0; ovf_clr = 1'b0;
        #1;
        check_reset_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b1, seq[i], err[i], 1'b0, 1'b0);
        check("three_push_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("drained_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 15) check("full_after_16", 32'(full), 32'd1);
        end
        check("overflow_after_17", 32'(overflow), 32'd1);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        check("drop_and_clr_keeps_ovf", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_alone", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        check("full_pushpop_count", 32'(count), 32'd16);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        check("empty_pushpop_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        n_push = 0;
        for (int it = 0; it < 400 && n_push < 40; it++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        check("random_push_total", 32'(n_push >= 40), 32'd1);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);

        // Pop requested, then reset lands before the edge that would accept it.
        @(negedge clk);
        rd_en = 1'b1; rx_ready = 1'b1; rx_data = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        rd_en = 1'b0; rx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
